// File: rtl/leak_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// leak_scheduler_pkg : shared FSM states, beta codes and widths for the leak
//                      scheduler slice.
// Revision: 1.0
// ============================================================================
package leak_scheduler_pkg;

   localparam int c_data_w = 8;
   localparam int c_ctrl_w = 4;
   localparam int c_beta_w = 4;

   localparam logic [c_beta_w-1:0] c_beta_x0     = 4'd0;
   localparam logic [c_beta_w-1:0] c_beta_x1     = 4'd1;
   localparam logic [c_beta_w-1:0] c_beta_x0_500 = 4'd2;
   localparam logic [c_beta_w-1:0] c_beta_x0_250 = 4'd3;
   localparam logic [c_beta_w-1:0] c_beta_x0_125 = 4'd4;
   localparam logic [c_beta_w-1:0] c_beta_x0_750 = 4'd5;
   localparam logic [c_beta_w-1:0] c_beta_x0_625 = 4'd6;
   localparam logic [c_beta_w-1:0] c_beta_x0_875 = 4'd7;
   localparam logic [c_beta_w-1:0] c_beta_x0_375 = 4'd8;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_MULT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

endpackage
`default_nettype wire

// File: rtl/leak_scheduler_if.sv
`default_nettype none
// ============================================================================
// leak_scheduler_if : potential-memory and shift-add multiplier bus.
// Revision: 1.0
// ============================================================================
interface leak_scheduler_if
   import leak_scheduler_pkg::*;
#(
   parameter int AW = 3
);
   logic                rd_en;
   logic [AW-1:0]       rd_addr;
   logic [c_data_w-1:0] rd_data;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [c_data_w-1:0] wr_data;
   logic [c_ctrl_w-1:0] mult_cntrl1;
   logic [c_ctrl_w-1:0] mult_cntrl2;
   logic [c_data_w-1:0] mult_pot;
   logic [c_data_w-1:0] mult_pot_1;
   logic [c_data_w-1:0] mult_pot_2;
   logic [c_data_w-1:0] mult_pot_3;
   logic [c_data_w-1:0] mult_ans;

   modport master (
      output rd_en, rd_addr, wr_en, wr_addr, wr_data,
      output mult_cntrl1, mult_cntrl2, mult_pot, mult_pot_1, mult_pot_2, mult_pot_3,
      input  rd_data, mult_ans
   );

   modport slave (
      input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
      input  mult_cntrl1, mult_cntrl2, mult_pot, mult_pot_1, mult_pot_2, mult_pot_3,
      output rd_data, mult_ans
   );
endinterface
`default_nettype wire

// File: rtl/leak_beta_decode.sv
`default_nettype none
// ============================================================================
// leak_beta_decode : maps a 4-bit leak code onto the multiplier select lines.
// Revision: 1.0
// ============================================================================
module leak_beta_decode
   import leak_scheduler_pkg::*;
(
   input  logic [c_beta_w-1:0] i_beta,
   output logic [c_ctrl_w-1:0] o_cntrl1,
   output logic [c_ctrl_w-1:0] o_cntrl2,
   output logic                o_err
);

   always_comb begin
      o_cntrl1 = '0;
      o_cntrl2 = '0;
      o_err    = 1'b0;
      case (i_beta)
         c_beta_x0     : ;
         c_beta_x1     : o_cntrl2 = 4'd1;
         c_beta_x0_500 : o_cntrl2 = 4'd2;
         c_beta_x0_250 : o_cntrl2 = 4'd3;
         c_beta_x0_125 : o_cntrl2 = 4'd4;
         c_beta_x0_750 : o_cntrl2 = 4'd5;
         c_beta_x0_625 : o_cntrl2 = 4'd6;
         c_beta_x0_875 : begin
            o_cntrl2 = 4'd6;
            o_cntrl1 = 4'd1;
         end
         c_beta_x0_375 : begin
            o_cntrl2 = 4'd6;
            o_cntrl1 = 4'd2;
         end
         // Illegal codes fall back to x0 so a bad code can only erase, never amplify.
         default       : o_err = 1'b1;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/leak_scheduler.sv
`default_nettype none
// ============================================================================
// leak_scheduler : sweeps the membrane-potential memory, applying a leak gain
//                  through an external shift-add multiplier (3 cycles/neuron).
// Revision: 1.0
// ============================================================================
module leak_scheduler
   import leak_scheduler_pkg::*;
#(
   parameter int N_NEURONS = 8,
   parameter int AW        = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [c_beta_w-1:0] beta,
   output logic                busy,
   output logic                done,
   output logic                beta_err,
   leak_scheduler_if.master    bus
);

   localparam logic [AW-1:0] c_last_idx = AW'(N_NEURONS - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [AW-1:0]       r_index;
   logic [c_data_w-1:0] r_operand;
   logic [c_ctrl_w-1:0] r_cntrl1;
   logic [c_ctrl_w-1:0] r_cntrl2;
   logic                r_beta_err;
   logic [c_ctrl_w-1:0] w_dec_cntrl1;
   logic [c_ctrl_w-1:0] w_dec_cntrl2;
   logic                w_dec_err;
   logic                w_rd_en;
   logic                w_wr_en;
   logic                w_done;

   leak_beta_decode u_beta_decode (
      .i_beta   (beta),
      .o_cntrl1 (w_dec_cntrl1),
      .o_cntrl2 (w_dec_cntrl2),
      .o_err    (w_dec_err)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_wr_en     = 1'b0;
      w_done      = 1'b0;
      case (r_state)
         ST_IDLE  : if (start) w_state_nxt = ST_READ;
         ST_READ  : begin
            w_rd_en     = 1'b1;
            w_state_nxt = ST_MULT;
         end
         ST_MULT  : w_state_nxt = ST_WRITE;
         ST_WRITE : begin
            w_wr_en     = 1'b1;
            w_state_nxt = (r_index == c_last_idx) ? ST_DONE : ST_READ;
         end
         ST_DONE  : begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default  : w_state_nxt = ST_IDLE;
      endcase
   end

   // Controls and error flag are captured only on an accepted start, so later
   // start pulses or beta changes cannot disturb a sweep in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_index    <= '0;
         r_operand  <= '0;
         r_cntrl1   <= '0;
         r_cntrl2   <= '0;
         r_beta_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE  : if (start) begin
               r_cntrl1   <= w_dec_cntrl1;
               r_cntrl2   <= w_dec_cntrl2;
               r_beta_err <= w_dec_err;
               r_index    <= '0;
            end
            ST_MULT  : r_operand <= bus.rd_data;
            ST_WRITE : if (r_index != c_last_idx) r_index <= r_index + AW'(1);
            default  : ;
         endcase
      end
   end

   assign busy     = (r_state != ST_IDLE);
   assign done     = w_done;
   assign beta_err = r_beta_err;

   assign bus.rd_en   = w_rd_en;
   assign bus.rd_addr = w_rd_en ? r_index : '0;
   assign bus.wr_en   = w_wr_en;
   assign bus.wr_addr = w_wr_en ? r_index : '0;
   assign bus.wr_data = w_wr_en ? bus.mult_ans : '0;

   // Zero selects while idle force the multiplier result to 0.
   assign bus.mult_cntrl1 = busy ? r_cntrl1 : '0;
   assign bus.mult_cntrl2 = busy ? r_cntrl2 : '0;
   assign bus.mult_pot    = r_operand;
   assign bus.mult_pot_1  = r_operand >> 1;
   assign bus.mult_pot_2  = r_operand >> 2;
   assign bus.mult_pot_3  = r_operand >> 3;

endmodule
`default_nettype wire

// File: tb/tb_leak_scheduler.sv
`default_nettype none
// ============================================================================
// tb_leak_scheduler : directed bench for leak_scheduler with memory and
//                     shift-add multiplier models.
// Revision: 1.0
// ============================================================================
module tb_leak_scheduler;

   localparam int N  = 8;
   localparam int AW = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] beta;
   logic       busy;
   logic       done;
   logic       beta_err;

   int errors = 0;
   int checks = 0;

   leak_scheduler_if #(.AW(AW)) bus ();

   leak_scheduler #(.N_NEURONS(N), .AW(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .beta     (beta),
      .busy     (busy),
      .done     (done),
      .beta_err (beta_err),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] mem [N];
   logic       fill_req = 1'b0;
   logic [7:0] fill_val = 8'd0;

   always @(posedge clk) begin
      if (fill_req) begin
         for (int i = 0; i < N; i++) mem[i] <= fill_val;
      end else if (bus.wr_en) begin
         mem[bus.wr_addr] <= bus.wr_data;
      end
      if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
   end

   // Shift-add multiplier: cntrl2 picks the base term, cntrl1 adds/subtracts pot>>2.
   always_comb begin
      logic [7:0] base;
      case (bus.mult_cntrl2)
         4'd1:    base = bus.mult_pot;
         4'd2:    base = bus.mult_pot_1;
         4'd3:    base = bus.mult_pot_2;
         4'd4:    base = bus.mult_pot_3;
         4'd5:    base = bus.mult_pot_1 + bus.mult_pot_2;
         4'd6:    base = bus.mult_pot_1 + bus.mult_pot_3;
         default: base = 8'd0;
      endcase
      case (bus.mult_cntrl1)
         4'd1:    bus.mult_ans = base + bus.mult_pot_2;
         4'd2:    bus.mult_ans = base - bus.mult_pot_2;
         default: bus.mult_ans = base;
      endcase
   end

   logic prev_done = 1'b0;
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         if ((bus.rd_en & bus.wr_en) !== 1'b0) begin
            errors++;
            $display("FAIL rd_wr_exclusive: rd_en=%b wr_en=%b, required not both 1", bus.rd_en, bus.wr_en);
         end
         checks++;
         if ((done === 1'b1) && (prev_done === 1'b1)) begin
            errors++;
            $display("FAIL done_width: done high two cycles in a row, required one-cycle pulse");
         end
      end
      prev_done = done;
   end

   task automatic fill_mem(input logic [7:0] v);
      @(negedge clk);
      fill_val = v;
      fill_req = 1'b1;
      @(negedge clk);
      fill_req = 1'b0;
   endtask

   task automatic run_sweep(input logic [3:0] b, input int ign1, input int ign2,
                            input logic [3:0] ign_beta, input logic exp_err);
      int         cyc;
      int         ph;
      int         idx;
      logic       got;
      logic [7:0] act;
      logic [7:0] exp;
      @(negedge clk);
      beta  = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      beta  = ign_beta;
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_on_accept: busy=%b required 1", busy);
      end
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 40) begin
         @(negedge clk);
         cyc++;
         start = (cyc == ign1) || (cyc == ign2);
         if (done === 1'b1) begin
            got = 1'b1;
            checks++;
            if (cyc != 3 * N + 1) begin
               errors++;
               $display("FAIL done_cycle: done at cycle %0d required %0d", cyc, 3 * N + 1);
            end
         end else if (cyc <= 3 * N) begin
            ph  = (cyc - 1) % 3;
            idx = (cyc - 1) / 3;
            exp = 8'd0;
            if (ph == 0)      exp = {1'b1, AW'(idx), 1'b0, 3'd0};
            else if (ph == 2) exp = {1'b0, 3'd0, 1'b1, AW'(idx)};
            act = {bus.rd_en, bus.rd_en ? bus.rd_addr : 3'd0, bus.wr_en, bus.wr_en ? bus.wr_addr : 3'd0};
            checks++;
            if (act !== exp) begin
               errors++;
               $display("FAIL seq_cycle%0d: {rd_en,rd_addr,wr_en,wr_addr}=%b required %b", cyc, act, exp);
            end
            checks++;
            if ({busy, beta_err} !== {1'b1, exp_err}) begin
               errors++;
               $display("FAIL busy_err_cycle%0d: busy,beta_err=%b%b required 1%b", cyc, busy, beta_err, exp_err);
            end
         end
      end
      if (!got) begin
         errors++;
         checks++;
         $display("FAIL done_timeout: no done within 40 cycles, required at %0d", 3 * N + 1);
         start = 1'b0;
         return;
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if ({busy, done} !== 2'b00) begin
         errors++;
         $display("FAIL after_done: busy,done=%b%b required 00", busy, done);
      end
   endtask

   task automatic test_reset();
      logic [58:0] v;
      rst   = 1'b1;
      start = 1'b0;
      beta  = 4'd0;
      #1;
      v = {busy, done, beta_err, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
           bus.mult_cntrl1, bus.mult_cntrl2, bus.mult_pot, bus.mult_pot_1, bus.mult_pot_2, bus.mult_pot_3};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL reset_outputs: %h required 0", v);
      end
      start = 1'b1;
      beta  = 4'd1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({busy, bus.rd_en} !== 2'b00) begin
         errors++;
         $display("FAIL reset_hold: busy,rd_en=%b%b required 00", busy, bus.rd_en);
      end
      start = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_unity();
      fill_mem(8'd100);
      run_sweep(4'd1, 0, 0, 4'd1, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== 8'd100) begin
            errors++;
            $display("FAIL unity_word%0d: %0d required 100", i, mem[i]);
         end
      end
   endtask

   task automatic test_leak_codes();
      int tbl [8][3] = '{'{7, 200, 175}, '{5, 200, 150}, '{8, 8, 3},    '{2, 201, 100},
                         '{3, 200, 50},  '{4, 200, 25},  '{6, 200, 125}, '{0, 77, 0}};
      for (int t = 0; t < 8; t++) begin
         fill_mem(8'(tbl[t][1]));
         run_sweep(4'(tbl[t][0]), 0, 0, 4'd0, 1'b0);
         for (int i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== 8'(tbl[t][2])) begin
               errors++;
               $display("FAIL code%0d_word%0d: %0d required %0d", tbl[t][0], i, mem[i], tbl[t][2]);
            end
         end
      end
   endtask

   task automatic test_illegal_beta();
      fill_mem(8'd90);
      run_sweep(4'd12, 0, 0, 4'd12, 1'b1);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== 8'd0) begin
            errors++;
            $display("FAIL illegal_word%0d: %0d required 0", i, mem[i]);
         end
      end
      fill_mem(8'd90);
      run_sweep(4'd2, 0, 0, 4'd2, 1'b0);
      checks++;
      if (mem[3] !== 8'd45) begin
         errors++;
         $display("FAIL legal_after_illegal: %0d required 45", mem[3]);
      end
   endtask

   task automatic test_start_ignored();
      fill_mem(8'd200);
      run_sweep(4'd5, 3, 10, 4'd13, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== 8'd150) begin
            errors++;
            $display("FAIL ignored_start_word%0d: %0d required 150", i, mem[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      fill_mem(8'd40);
      run_sweep(4'd2, 3 * N + 1, 0, 4'd1, 1'b0);
      checks++;
      if ({bus.mult_cntrl1, bus.mult_cntrl2} !== 8'd0) begin
         errors++;
         $display("FAIL idle_selects: %h required 00", {bus.mult_cntrl1, bus.mult_cntrl2});
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL start_with_done: busy=%b required 0", busy);
      end
      run_sweep(4'd2, 0, 0, 4'd2, 1'b0);
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== 8'd10) begin
            errors++;
            $display("FAIL back_to_back_word%0d: %0d required 10", i, mem[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [58:0] v;
      logic        saw;
      fill_mem(8'd200);
      @(negedge clk);
      beta  = 4'd0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.wr_addr} !== {1'b1, 3'd4}) begin
         errors++;
         $display("FAIL mid_reach_write4: wr_en,wr_addr=%b,%0d required 1,4", bus.wr_en, bus.wr_addr);
      end
      rst = 1'b1;
      #1;
      v = {busy, done, beta_err, bus.rd_en, bus.rd_addr, bus.wr_en, bus.wr_addr, bus.wr_data,
           bus.mult_cntrl1, bus.mult_cntrl2, bus.mult_pot, bus.mult_pot_1, bus.mult_pot_2, bus.mult_pot_3};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: %h required 0", v);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      saw = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || bus.wr_en !== 1'b0) saw = 1'b1;
      end
      checks++;
      if (saw !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset_quiet: activity after abort, required none");
      end
      for (int i = 0; i < N; i++) begin
         checks++;
         if (mem[i] !== ((i < 4) ? 8'd0 : 8'd200)) begin
            errors++;
            $display("FAIL mid_reset_word%0d: %0d required %0d", i, mem[i], (i < 4) ? 0 : 200);
         end
      end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_leak_codes();
      test_illegal_beta();
      test_start_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
